// File: rtl/parity_pkg.sv
// Constants shared by the parity frame generator and checker.
// Covers frame geometry, parity sense and checker FSM encodings.
package parity_pkg;

    localparam int FRAME_DATA_W = 5;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_CHECK = 2'd2;

    // XOR reduction of a frame word; used by the generator to build the parity bit.
    function automatic logic parity_of(input logic [FRAME_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Shared by error and statistics counters.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_check_rx.sv
// Receive-side parity checker: shifts in DATA_W data bits MSB first plus one
// parity bit, publishes the word and parity verdict, and counts bad frames.
module parity_check_rx
    import parity_pkg::*;
#(
    parameter int DATA_W  = FRAME_DATA_W,
    parameter int ODD_PAR = PAR_EVEN,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              bit_en,
    input  logic              sin,
    input  logic              clr_cnt,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              par_err,
    output logic              valid,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int   BCNT_W  = $clog2(DATA_W + 2);
    localparam logic PAR_EXP = (ODD_PAR != 0);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BCNT_W-1:0] bit_cnt;
    logic              par_x;
    logic              last_bit;
    logic              frame_err;
    logic              cnt_inc;

    // bit_cnt == DATA_W means the bit being consumed now is the parity bit
    assign last_bit  = (bit_cnt == BCNT_W'(DATA_W));
    assign frame_err = (par_x != PAR_EXP);
    assign cnt_inc   = (state == ST_CHECK) && frame_err;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            par_x    <= 1'b0;
            data_out <= '0;
            par_err  <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        par_x   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_en) begin
                        par_x   <= par_x ^ sin;
                        bit_cnt <= bit_cnt + BCNT_W'(1);
                        if (last_bit) begin
                            state <= ST_CHECK;
                        end else begin
                            shreg <= DATA_W'({shreg, sin});
                        end
                    end
                end
                ST_CHECK: begin
                    data_out <= shreg;
                    par_err  <= frame_err;
                    valid    <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (cnt_inc),
        .clr   (clr_cnt),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed table-driven bench for parity_check_rx, built with a 2-bit error
// counter so that saturation is reachable in a handful of frames.
module tb_parity_check_rx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       bit_en;
    logic       sin;
    logic       clr_cnt;
    logic       busy;
    logic [4:0] data_out;
    logic       par_err;
    logic       valid;
    logic [1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [4:0] d;
        logic       p;
        bit         stall;
        bit         mid_start;
        bit         clr_chk;
        logic [4:0] exp_d;
        logic       exp_perr;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];

    parity_check_rx #(
        .DATA_W  (5),
        .ODD_PAR (0),
        .CNT_W   (2)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .bit_en   (bit_en),
        .sin      (sin),
        .clr_cnt  (clr_cnt),
        .busy     (busy),
        .data_out (data_out),
        .par_err  (par_err),
        .valid    (valid),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts in the current cycle (caller is mid-cycle), returns at the
    // falling edge where valid is first seen high, or after the bound.
    task automatic send_frame(input logic [4:0] d, input logic p, input bit stall,
                              input bit mid_start, input bit clr_chk, output int lat);
        logic [5:0] fr;
        fr = {d, p};
        start  = 1'b1;
        bit_en = 1'b1;
        sin    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bit_en = 1'b0;
        @(negedge clk);
        check("valid_single", 32'(valid), 0);
        check("busy_start", 32'(busy), 1);
        for (int i = 5; i >= 0; i--) begin
            sin    = fr[i];
            bit_en = 1'b1;
            @(posedge clk); #1;
            bit_en = 1'b0;
            sin    = ~sin;
            if (mid_start && i == 3) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (stall && i > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("busy_stall", 32'(busy), 1);
                @(posedge clk); #1;
            end
        end
        if (clr_chk) clr_cnt = 1'b1;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 2) clr_cnt = 1'b0;
            if (valid) begin
                lat = n;
                break;
            end
        end
        clr_cnt = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{5'h16, 1'b1, 1'b0, 1'b0, 1'b0, 5'h16, 1'b0, 2'd0};
        vecs[1]  = '{5'h16, 1'b0, 1'b0, 1'b0, 1'b0, 5'h16, 1'b1, 2'd1};
        vecs[2]  = '{5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'd1};
        vecs[3]  = '{5'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 5'h1F, 1'b0, 2'd1};
        vecs[4]  = '{5'h0A, 1'b0, 1'b0, 1'b1, 1'b0, 5'h0A, 1'b0, 2'd1};
        vecs[5]  = '{5'h01, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, 1'b1, 2'd0};
        vecs[6]  = '{5'h16, 1'b0, 1'b0, 1'b0, 1'b0, 5'h16, 1'b1, 2'd1};
        vecs[7]  = '{5'h03, 1'b1, 1'b0, 1'b0, 1'b0, 5'h03, 1'b1, 2'd2};
        vecs[8]  = '{5'h1F, 1'b0, 1'b1, 1'b0, 1'b0, 5'h1F, 1'b1, 2'd3};
        vecs[9]  = '{5'h10, 1'b0, 1'b0, 1'b0, 1'b0, 5'h10, 1'b1, 2'd3};
        vecs[10] = '{5'h07, 1'b0, 1'b0, 1'b0, 1'b1, 5'h07, 1'b1, 2'd0};
        vecs[11] = '{5'h15, 1'b1, 1'b0, 1'b0, 1'b0, 5'h15, 1'b0, 2'd0};
        vecs[12] = '{5'h16, 1'b0, 1'b0, 1'b0, 1'b0, 5'h16, 1'b1, 2'd1};

        n_rst   = 1'b0;
        start   = 1'b0;
        bit_en  = 1'b0;
        sin     = 1'b0;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data_out), 0);
        check("rst_perr", 32'(par_err), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(err_cnt), 0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            send_frame(vecs[v].d, vecs[v].p, vecs[v].stall, vecs[v].mid_start,
                       vecs[v].clr_chk, lat);
            check($sformatf("latency[%0d]", v), lat, 2);
            check($sformatf("data[%0d]", v), 32'(data_out), 32'(vecs[v].exp_d));
            check($sformatf("perr[%0d]", v), 32'(par_err), 32'(vecs[v].exp_perr));
            check($sformatf("cnt[%0d]", v), 32'(err_cnt), 32'(vecs[v].exp_cnt));
        end

        // Idle gap: outputs hold, no stray valid
        repeat (4) @(negedge clk);
        check("idle_valid", 32'(valid), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_data", 32'(data_out), 32'h16);
        check("idle_perr", 32'(par_err), 1);
        check("idle_cnt", 32'(err_cnt), 1);

        // Reset after three bits of a frame
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bit_en = 1'b1;
        sin    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bit_en = 1'b0;
        check("pre_rst_busy", 32'(busy), 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_out), 0);
        check("mid_rst_perr", 32'(par_err), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cnt", 32'(err_cnt), 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) seen++;
        end
        n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (valid || busy) seen++;
        end
        check("rst_no_valid", seen, 0);

        send_frame(5'h0A, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_data", 32'(data_out), 32'h0A);
        check("post_rst_perr", 32'(par_err), 0);
        check("post_rst_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        check("post_rst_single", 32'(valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
Serial receive-side checker for the team's 5-bit + parity frame. It shifts in one frame of DATA_W data bits, MSB first, followed by one parity bit, all under a bit-enable strobe. It recovers the data word, checks parity, pulses a valid strobe, and keeps a saturating error count. It sits at the link end opposite the parity generator.

Parameters:
DATA_W, 5, number of data bits per frame (frame length = DATA_W+1)
ODD_PAR, 0, 0 = even parity expected (XOR of all frame bits = 0); 1 = odd parity expected (XOR = 1)
CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  start-of-frame pulse; sampled only in IDLE
bit_en  in  1  qualifies sin; one frame bit consumed per cycle with bit_en=1 in SHIFT
sin  in  1  serial frame bit
clr_cnt  in  1  synchronous clear of err_cnt
busy  out  1  high in SHIFT and CHECK states
data_out  out  DATA_W  last received data word, held until next frame completes
par_err  out  1  parity result of last frame, held with data_out
valid  out  1  one-cycle pulse when data_out/par_err update
err_cnt  out  CNT_W  number of frames with parity error, saturating

Behaviour:
- Reset (n_rst=0, async): state=IDLE; data_out=0, par_err=0, valid=0, busy=0, err_cnt=0; shift register, bit counter and running XOR cleared.
- States: IDLE, SHIFT, CHECK.
- IDLE: start=1 -> SHIFT; bit counter=0; running XOR=0. sin/bit_en ignored in IDLE, including in the start cycle.
- SHIFT: each cycle with bit_en=1: shift sin into shift register LSB (MSB-first arrival); XOR sin into running parity; increment counter. bit_en=0 -> hold all state (stall, unbounded). When bit DATA_W+1 (the parity bit) is consumed -> CHECK. The parity bit enters the XOR but is not stored in data_out.
- CHECK (one cycle): data_out <= shift register[DATA_W-1:0]; par_err <= (running XOR != ODD_PAR); valid <= 1 on the same edge, so valid is high during the cycle after CHECK. err_cnt increments if the error condition holds. Next state is IDLE.
- Latency: valid is high exactly 2 cycles after the edge that samples the parity bit. valid is never high for 2 consecutive cycles.
- start while busy=1: ignored. A new frame can begin on the cycle valid is high (state is already IDLE).
- err_cnt saturates at 2^CNT_W-1 and does not wrap. clr_cnt=1 -> err_cnt=0 next edge. clr_cnt and an increment on the same edge -> clear wins (result 0).
- Reset mid-frame: partial frame discarded, no valid pulse, all outputs return to reset values.
- data_out/par_err change only at CHECK; they hold through later idle and shift periods.

Decomposition:
- Package parity_pkg: state enum (IDLE/SHIFT/CHECK), FRAME_DATA_W=5, PAR_EVEN=0 / PAR_ODD=1 constants shared with the generator.
- One sub-module is natural: sat_counter (CNT_W parameter; inc, clr inputs; clr priority). It is reusable for other error/statistic counters.

Test Plan:
- Clean even frame: start, then bits 1,0,1,1,0 then parity 1, bit_en=1 each cycle -> valid pulse, data_out=5'h16, par_err=0, err_cnt=0.
- Corrupted frame: same data, parity bit 0 -> data_out=5'h16, par_err=1, err_cnt=1. Next clean frame 5'h00 with parity 0 -> par_err=0, err_cnt stays 1.
- Stalls: 5'h1F with parity 1, bit_en toggled 1,0,0,1,... -> result identical to no-stall case (par_err=0). valid timing is relative to the last sampled bit. busy stays high throughout the frame.
- Saturation and clear (CNT_W=2): 4 errored frames -> err_cnt=3 after the 3rd and 4th. clr_cnt asserted on the CHECK edge of a 5th errored frame -> err_cnt=0.
- Protocol edges: start pulsed mid-SHIFT -> ignored, frame completes normally. start on the valid cycle -> back-to-back frame accepted.
- Reset after 3 bits shifted -> outputs 0, no valid. A following full frame 5'h0A with parity 0 -> data_out=5'h0A, par_err=0.
